// File: rtl/mem_port_arbiter_pkg.sv
// ============================================================
// mem_arb_pkg : owner tags and shared constants for the memory port arbiter
// Revision 1.0 : initial release
// ============================================================
`default_nettype none

package mem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } owner_t;

  localparam int MEM_LAT_MIN = 1;
  localparam int MEM_LAT_MAX = 4;

  // Streak counter width; STARVE_MAX must fit in it.
  localparam int STREAK_W = 4;

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
// ============================================================
// mem_port_arbiter_if : requester and memory bus bundle for the arbiter
// Revision 1.0 : initial release
// ============================================================
`default_nettype none

interface mem_port_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_flush;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;
  logic [ADDR_W-1:0] mem_a;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_read;
  logic              mem_write;
  logic [DATA_W-1:0] mem_rdata;
  logic [1:0]        align_err;

  modport master (
    output if_req, if_addr, if_flush, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
    input  mem_a, mem_wdata, mem_read, mem_write, align_err
  );

  modport slave (
    input  if_req, if_addr, if_flush, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
    output mem_a, mem_wdata, mem_read, mem_write, align_err
  );

endinterface

`default_nettype wire

// File: rtl/mem_port_arbiter_resp_tag_pipe.sv
// ============================================================
// resp_tag_pipe : fixed-latency owner shift register with fetch-flush rewrite
// Revision 1.0 : initial release
// ============================================================
`default_nettype none

module resp_tag_pipe
  import mem_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic   clk,
  input  logic   reset,
  input  owner_t push_tag,
  input  logic   flush,
  output owner_t head_tag
);

  owner_t tags_q [DEPTH];
  owner_t tags_d [DEPTH];

  always_comb begin
    tags_d[0] = push_tag;
    for (int i = 1; i < DEPTH; i++) begin
      tags_d[i] = tags_q[i-1];
    end
    // Flush kills every fetch tag, including the one being loaded this cycle.
    for (int i = 0; i < DEPTH; i++) begin
      if (flush && (tags_d[i] == OWN_IF)) begin
        tags_d[i] = OWN_NONE;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        tags_q[i] <= OWN_NONE;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        tags_q[i] <= tags_d[i];
      end
    end
  end

  assign head_tag = tags_q[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================
// mem_port_arbiter : shares one memory port between fetch and data requesters
// Revision 1.0 : initial release
// ============================================================
`default_nettype none

module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clk_en,
  mem_port_arbiter_if.slave  bus
);

  localparam logic [STREAK_W-1:0] c_starve_max = STREAK_W'(STARVE_MAX);

  logic [STREAK_W-1:0] streak_q, streak_d;
  logic [ADDR_W-1:0]   mem_a_q, mem_a_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                mem_read_q, mem_read_d;
  logic                mem_write_q, mem_write_d;
  logic [1:0]          align_err_q, align_err_d;

  logic   w_starve;
  logic   w_if_gnt;
  logic   w_d_gnt;
  owner_t w_push_tag;
  owner_t w_head_tag;

  // A starved fetch beats data; a flushing fetch still blocks data that cycle.
  assign w_starve = (streak_q == c_starve_max) && bus.if_req;
  assign w_d_gnt  = !reset && clk_en && bus.d_req && !w_starve;
  assign w_if_gnt = !reset && clk_en && bus.if_req && !bus.if_flush &&
                    (!bus.d_req || w_starve);

  always_comb begin
    streak_d    = streak_q;
    mem_a_d     = mem_a_q;
    mem_wdata_d = mem_wdata_q;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    align_err_d = align_err_q;
    w_push_tag  = OWN_NONE;

    if (!bus.if_req || w_if_gnt) begin
      streak_d = '0;
    end else if (w_d_gnt && (streak_q != c_starve_max)) begin
      streak_d = streak_q + 1'b1;
    end

    if (w_d_gnt) begin
      mem_a_d        = {bus.d_addr[ADDR_W-1:2], 2'b00};
      mem_wdata_d    = bus.d_wdata;
      mem_read_d     = !bus.d_we;
      mem_write_d    = bus.d_we;
      w_push_tag     = bus.d_we ? OWN_NONE : OWN_D;
      align_err_d[1] = align_err_q[1] | (bus.d_addr[1:0] != 2'b00);
    end else if (w_if_gnt) begin
      mem_a_d        = {bus.if_addr[ADDR_W-1:2], 2'b00};
      mem_read_d     = 1'b1;
      w_push_tag     = OWN_IF;
      align_err_d[0] = align_err_q[0] | (bus.if_addr[1:0] != 2'b00);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      streak_q    <= '0;
      mem_a_q     <= '0;
      mem_wdata_q <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      align_err_q <= 2'b00;
    end else begin
      streak_q    <= streak_d;
      mem_a_q     <= mem_a_d;
      mem_wdata_q <= mem_wdata_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      align_err_q <= align_err_d;
    end
  end

  // Head of a MEM_LAT+1 deep pipe lines up with mem_rdata of the granted read.
  resp_tag_pipe #(
    .DEPTH (MEM_LAT + 1)
  ) u_resp_tag_pipe (
    .clk      (clk),
    .reset    (reset),
    .push_tag (w_push_tag),
    .flush    (bus.if_flush),
    .head_tag (w_head_tag)
  );

  assign bus.if_gnt    = w_if_gnt;
  assign bus.d_gnt     = w_d_gnt;
  assign bus.if_rvalid = (w_head_tag == OWN_IF) && !bus.if_flush;
  assign bus.d_rvalid  = (w_head_tag == OWN_D);
  assign bus.if_rdata  = bus.if_rvalid ? bus.mem_rdata : {DATA_W{1'b0}};
  assign bus.d_rdata   = bus.d_rvalid  ? bus.mem_rdata : {DATA_W{1'b0}};
  assign bus.mem_a     = mem_a_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_read  = mem_read_q;
  assign bus.mem_write = mem_write_q;
  assign bus.align_err = align_err_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================
// tb_mem_port_arbiter : directed checks of arbitration, latency, flush, reset
// Revision 1.0 : initial release
// ============================================================
`default_nettype none

module tb_mem_port_arbiter;

  logic        clk;
  logic        reset;
  logic        clk_en;
  logic        if_req, if_flush, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata, rdata;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b1 ();
  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b2 ();
  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b3 ();

  assign b1.if_req = if_req;   assign b2.if_req = if_req;   assign b3.if_req = if_req;
  assign b1.if_addr = if_addr; assign b2.if_addr = if_addr; assign b3.if_addr = if_addr;
  assign b1.if_flush = if_flush; assign b2.if_flush = if_flush; assign b3.if_flush = if_flush;
  assign b1.d_req = d_req;     assign b2.d_req = d_req;     assign b3.d_req = d_req;
  assign b1.d_we = d_we;       assign b2.d_we = d_we;       assign b3.d_we = d_we;
  assign b1.d_addr = d_addr;   assign b2.d_addr = d_addr;   assign b3.d_addr = d_addr;
  assign b1.d_wdata = d_wdata; assign b2.d_wdata = d_wdata; assign b3.d_wdata = d_wdata;
  assign b1.mem_rdata = rdata; assign b2.mem_rdata = rdata; assign b3.mem_rdata = rdata;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)) u1 (
    .clk(clk), .reset(reset), .clk_en(clk_en), .bus(b1.slave));
  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .STARVE_MAX(4)) u2 (
    .clk(clk), .reset(reset), .clk_en(clk_en), .bus(b2.slave));
  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .STARVE_MAX(4)) u3 (
    .clk(clk), .reset(reset), .clk_en(clk_en), .bus(b3.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    if_req = 1'b0; if_flush = 1'b0; d_req = 1'b0; d_we = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; clk_en = 1'b1; idle();
    if_addr = '0; d_addr = '0; d_wdata = '0; rdata = '0;
    tick(); tick();
    chk("rst_mem_read", b1.mem_read, 0);
    chk("rst_mem_a", b1.mem_a, 0);
    chk("rst_align", b1.align_err, 0);
    chk("rst_rvalid", {b1.if_rvalid, b1.d_rvalid}, 0);
    reset = 1'b0;
    tick();

    // Single fetch, MEM_LAT=1
    if_req = 1'b1; if_addr = 32'h10; #1;
    chk("t1_if_gnt", b1.if_gnt, 1);
    chk("t1_d_gnt", b1.d_gnt, 0);
    tick(); idle(); #1;
    chk("t1_mem_read", b1.mem_read, 1);
    chk("t1_mem_a", b1.mem_a, 32'h10);
    chk("t1_if_rvalid_early", b1.if_rvalid, 0);
    tick(); rdata = 32'h1111_0001; #1;
    chk("t1_if_rvalid", b1.if_rvalid, 1);
    chk("t1_if_rdata", b1.if_rdata, 32'h1111_0001);
    chk("t1_d_rvalid", b1.d_rvalid, 0);

    // D over IF, then IF
    tick(); tick();
    if_req = 1'b1; if_addr = 32'h40; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100; #1;
    chk("t2_d_gnt0", b1.d_gnt, 1);
    chk("t2_if_gnt0", b1.if_gnt, 0);
    tick(); d_req = 1'b0; #1;
    chk("t2_if_gnt1", b1.if_gnt, 1);
    chk("t2_mem_read1", b1.mem_read, 1);
    chk("t2_mem_a1", b1.mem_a, 32'h100);
    tick(); if_req = 1'b0; rdata = 32'hAAAA_0002; #1;
    chk("t2_d_rvalid2", b1.d_rvalid, 1);
    chk("t2_d_rdata2", b1.d_rdata, 32'hAAAA_0002);
    chk("t2_if_rvalid2", b1.if_rvalid, 0);
    chk("t2_mem_a2", b1.mem_a, 32'h40);
    tick(); rdata = 32'hBBBB_0003; #1;
    chk("t2_if_rvalid3", b1.if_rvalid, 1);
    chk("t2_if_rdata3", b1.if_rdata, 32'hBBBB_0003);
    chk("t2_d_rvalid3", b1.d_rvalid, 0);

    // Starvation: D wins 4 times, then IF, then D again
    tick();
    d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'h55; if_addr = 32'h300;
    for (int c = 0; c < 7; c++) begin
      if_req = 1'b1; d_req = 1'b1; #1;
      chk("t3_if_gnt", b1.if_gnt, (c == 4) ? 32'd1 : 32'd0);
      chk("t3_d_gnt", b1.d_gnt, (c == 4) ? 32'd0 : 32'd1);
      tick();
    end
    idle();
    tick(); tick(); tick(); tick();

    // Flush with MEM_LAT=2
    if_req = 1'b1; if_addr = 32'h80; #1;
    chk("t4_if_gnt0", b2.if_gnt, 1);
    tick(); if_flush = 1'b1; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h104; #1;
    chk("t4_if_gnt1", b2.if_gnt, 0);
    chk("t4_d_gnt1", b2.d_gnt, 1);
    tick(); idle(); #1;
    tick(); rdata = 32'h3333_0003; #1;
    chk("t4_if_rvalid3", b2.if_rvalid, 0);
    chk("t4_d_rvalid3", b2.d_rvalid, 0);
    tick(); rdata = 32'h2222_0004; #1;
    chk("t4_d_rvalid4", b2.d_rvalid, 1);
    chk("t4_d_rdata4", b2.d_rdata, 32'h2222_0004);
    chk("t4_if_rvalid4", b2.if_rvalid, 0);

    // Misaligned store
    tick();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h22; d_wdata = 32'hDEAD_BEEF; #1;
    chk("t5_d_gnt", b1.d_gnt, 1);
    chk("t5_align0", b1.align_err, 0);
    tick(); idle(); #1;
    chk("t5_mem_write", b1.mem_write, 1);
    chk("t5_mem_read", b1.mem_read, 0);
    chk("t5_mem_a", b1.mem_a, 32'h20);
    chk("t5_mem_wdata", b1.mem_wdata, 32'hDEAD_BEEF);
    chk("t5_align1", b1.align_err, 32'h2);
    tick(); #1;
    chk("t5_d_rvalid2", b1.d_rvalid, 0);
    chk("t5_mem_write2", b1.mem_write, 0);
    chk("t5_align2", b1.align_err, 32'h2);
    tick(); #1;
    chk("t5_d_rvalid3", b1.d_rvalid, 0);

    // Reset mid-flight with MEM_LAT=3, then clk_en gating
    tick(); tick(); tick();
    if_req = 1'b1; if_addr = 32'h30; #1;
    chk("t6_if_gnt0", b3.if_gnt, 1);
    tick(); reset = 1'b1; #1;
    chk("t6_rst_mem_read", b3.mem_read, 0);
    chk("t6_rst_if_gnt", b3.if_gnt, 0);
    chk("t6_rst_mem_a", b3.mem_a, 0);
    chk("t6_rst_align", b1.align_err, 0);
    tick(); reset = 1'b0; idle();
    for (int c = 0; c < 10; c++) begin
      #1;
      chk("t6_no_rvalid", {b3.if_rvalid, b3.d_rvalid}, 0);
      tick();
    end
    clk_en = 1'b0; if_req = 1'b1; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h8; #1;
    chk("t6_en_if_gnt", b3.if_gnt, 0);
    chk("t6_en_d_gnt", b3.d_gnt, 0);
    tick(); #1;
    chk("t6_en_mem_read", b3.mem_read, 0);
    chk("t6_en_d_gnt2", b3.d_gnt, 0);
    clk_en = 1'b1; #1;
    chk("t6_en_resume", b3.d_gnt, 1);
    idle();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
